// File: rtl/gauss_rand_feeder_pkg.sv
// Shared constants, width helper and FSM encoding for the gauss sampler randomness feeder.
package gauss_pkg;

  localparam int RANDOM_WIDTH = 128;
  localparam int IN_WIDTH     = 64;
  localparam int PARALLELISM  = 4;
  localparam int N_COEFFS     = 256;
  localparam int TARGET       = N_COEFFS / PARALLELISM;
  localparam int BEATS        = RANDOM_WIDTH / IN_WIDTH;

  // Never returns 0 so the result is always usable as a vector width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

  localparam int BEAT_W = clog2(BEATS);
  localparam int CNT_W  = clog2(TARGET + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    OFFER = 2'd2
  } state_e;

endpackage

// File: rtl/gauss_rand_feeder_if.sv
// Bundles the XOF input stream, the sampler random/sigma handshake and the sample strobe.
interface gauss_rand_feeder_if;
  import gauss_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [IN_WIDTH-1:0]     in_data;
  logic                    random_valid;
  logic                    random_ready;
  logic [RANDOM_WIDTH-1:0] random_in;
  logic [7:0]              sigma;
  logic                    sample_valid;
  logic                    coeff_keep;

  modport master (
    input  in_valid, in_data, random_ready, sample_valid,
    output in_ready, random_valid, random_in, sigma, coeff_keep
  );

  modport slave (
    output in_valid, in_data, random_ready, sample_valid,
    input  in_ready, random_valid, random_in, sigma, coeff_keep
  );
endinterface

// File: rtl/gauss_width_packer.sv
// Assembles IN_WIDTH beats LSB-first into one RANDOM_WIDTH word; flush restarts at beat 0.
module gauss_width_packer
  import gauss_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    beat_vld_i,
  input  logic [IN_WIDTH-1:0]     beat_dat_i,
  output logic                    last_beat_o,
  output logic [RANDOM_WIDTH-1:0] word_o
);

  logic [BEAT_W-1:0]       beat_q;
  logic [RANDOM_WIDTH-1:0] word_q;

  assign last_beat_o = (beat_q == BEAT_W'(BEATS - 1));
  assign word_o      = word_q;

  // Flush wins over a simultaneous beat so a terminated run leaves no stray half-word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q <= '0;
      word_q <= '0;
    end else if (flush_i) begin
      beat_q <= '0;
    end else if (beat_vld_i) begin
      word_q[IN_WIDTH*beat_q +: IN_WIDTH] <= beat_dat_i;
      beat_q <= last_beat_o ? '0 : beat_q + BEAT_W'(1);
    end
  end

endmodule

// File: rtl/gauss_rand_feeder.sv
// Feeds packed XOF words and a held sigma to the sampler, counts samples and stops after one polynomial.
module gauss_rand_feeder
  import gauss_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          sigma_cfg,
  gauss_rand_feeder_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    sample_count
);

  state_e           state_q;
  logic [7:0]       sigma_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             done_q;
  logic             last_beat;
  logic             beat_acc;
  logic             count_inc;
  logic             terminate;

  assign beat_acc  = bus.in_valid && (state_q == FILL);
  assign count_inc = bus.sample_valid && (state_q != IDLE) && (count_q < CNT_W'(TARGET));
  assign count_d   = count_q + CNT_W'(1);
  assign terminate = count_inc && (count_d == CNT_W'(TARGET));

  assign bus.in_ready     = (state_q == FILL);
  assign bus.random_valid = (state_q == OFFER);
  assign bus.sigma        = sigma_q;
  assign bus.coeff_keep   = count_inc;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign sample_count     = count_q;

  gauss_width_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     ((state_q == IDLE) || terminate),
    .beat_vld_i  (beat_acc),
    .beat_dat_i  (bus.in_data),
    .last_beat_o (last_beat),
    .word_o      (bus.random_in)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sigma_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sigma_q <= sigma_cfg;
            count_q <= '0;
            state_q <= FILL;
          end
        end
        FILL:    if (beat_acc && last_beat) state_q <= OFFER;
        OFFER:   if (bus.random_ready) state_q <= FILL;
        default: state_q <= IDLE;
      endcase
      if (count_inc) count_q <= count_d;
      // Reaching the target overrides any handshake progress made in the same cycle.
      if (terminate) begin
        state_q <= IDLE;
        done_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gauss_rand_feeder.sv
// Directed vector table plus hand sequences for backpressure, termination, reset and a full run.
module tb_gauss_rand_feeder;
  import gauss_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [7:0]       sigma_cfg;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_count;

  int errors = 0;
  int checks = 0;

  gauss_rand_feeder_if bus ();

  gauss_rand_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .sigma_cfg    (sigma_cfg),
    .bus          (bus.master),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0]  BA = 64'h629F6FBED82C07CD;
  localparam logic [63:0]  BB = 64'hE3E70682C2094CAC;
  localparam logic [127:0] WAB = {BB, BA};

  typedef struct {
    logic         start;
    logic [7:0]   sigma_cfg;
    logic         in_valid;
    logic [63:0]  in_data;
    logic         random_ready;
    logic         sample_valid;
    logic         exp_in_ready;
    logic         exp_rv;
    logic [127:0] exp_rin;
    logic [7:0]   exp_sigma;
    logic         exp_busy;
    logic         exp_done;
    logic [6:0]   exp_cnt;
    logic         exp_keep;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] sc, input logic iv, input logic [63:0] id,
                       input logic rr, input logic sv);
    @(negedge clk);
    start = st;
    sigma_cfg = sc;
    bus.in_valid = iv;
    bus.in_data = id;
    bus.random_ready = rr;
    bus.sample_valid = sv;
    #1;
  endtask

  int keep_cnt;
  int done_cnt;
  int post;
  logic [1:0] pipe;
  logic [63:0] rnd;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sigma_cfg = 8'd0;
    bus.in_valid = 1'b1;
    bus.in_data = 64'h0;
    bus.random_ready = 1'b0;
    bus.sample_valid = 1'b0;

    vecs[0] = '{1'b1, 8'd4, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0, 8'd0, 1'b0, 1'b0, 7'd0, 1'b0};
    vecs[1] = '{1'b1, 8'd9, 1'b1, BA, 1'b0, 1'b0, 1'b1, 1'b0, 128'h0, 8'd4, 1'b1, 1'b0, 7'd0, 1'b0};
    vecs[2] = '{1'b0, 8'd0, 1'b1, BB, 1'b0, 1'b0, 1'b1, 1'b0, {64'h0, BA}, 8'd4, 1'b1, 1'b0, 7'd0, 1'b0};
    vecs[3] = '{1'b0, 8'd0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b1, WAB, 8'd4, 1'b1, 1'b0, 7'd0, 1'b1};
    vecs[4] = '{1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, WAB, 8'd4, 1'b1, 1'b0, 7'd1, 1'b0};
    vecs[5] = '{1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, WAB, 8'd4, 1'b1, 1'b0, 7'd1, 1'b1};
    vecs[6] = '{1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, WAB, 8'd4, 1'b1, 1'b0, 7'd2, 1'b0};

    // Reset held three cycles with in_valid asserted
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    chk("rst.in_ready", 128'(bus.in_ready), 128'd0);
    chk("rst.random_valid", 128'(bus.random_valid), 128'd0);
    chk("rst.sigma", 128'(bus.sigma), 128'd0);
    chk("rst.sample_count", 128'(sample_count), 128'd0);
    chk("rst.done", 128'(done), 128'd0);
    chk("rst.random_in", bus.random_in, 128'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].start, vecs[i].sigma_cfg, vecs[i].in_valid, vecs[i].in_data,
            vecs[i].random_ready, vecs[i].sample_valid);
      chk($sformatf("vec%0d.in_ready", i), 128'(bus.in_ready), 128'(vecs[i].exp_in_ready));
      chk($sformatf("vec%0d.random_valid", i), 128'(bus.random_valid), 128'(vecs[i].exp_rv));
      chk($sformatf("vec%0d.random_in", i), bus.random_in, vecs[i].exp_rin);
      chk($sformatf("vec%0d.sigma", i), 128'(bus.sigma), 128'(vecs[i].exp_sigma));
      chk($sformatf("vec%0d.busy", i), 128'(busy), 128'(vecs[i].exp_busy));
      chk($sformatf("vec%0d.done", i), 128'(done), 128'(vecs[i].exp_done));
      chk($sformatf("vec%0d.count", i), 128'(sample_count), 128'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d.keep", i), 128'(bus.coeff_keep), 128'(vecs[i].exp_keep));
    end

    // Backpressure: word {D,C} must stay put while a third beat waits on the input
    drive(1'b0, 8'd0, 1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 64'h5555_6666_7777_8888, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'd0, 1'b1, 64'h9999_AAAA_BBBB_CCCC, 1'b0, 1'b0);
      chk($sformatf("bp%0d.random_valid", i), 128'(bus.random_valid), 128'd1);
      chk($sformatf("bp%0d.in_ready", i), 128'(bus.in_ready), 128'd0);
      chk($sformatf("bp%0d.random_in", i), bus.random_in,
          128'h5555_6666_7777_8888_1111_2222_3333_4444);
    end
    drive(1'b0, 8'd0, 1'b0, 64'h0, 1'b1, 1'b0);
    chk("bp.hs_valid", 128'(bus.random_valid), 128'd1);
    drive(1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("bp.refill_in_ready", 128'(bus.in_ready), 128'd1);
    chk("bp.refill_valid", 128'(bus.random_valid), 128'd0);

    // Termination after beat 0 of a new word
    for (int i = 0; i < 61; i++) drive(1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("term.count63", 128'(sample_count), 128'd63);
    drive(1'b0, 8'd0, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
    chk("term.beat0_ready", 128'(bus.in_ready), 128'd1);
    drive(1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b1);
    chk("term.last_keep", 128'(bus.coeff_keep), 128'd1);
    drive(1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("term.done", 128'(done), 128'd1);
    chk("term.busy", 128'(busy), 128'd0);
    chk("term.in_ready", 128'(bus.in_ready), 128'd0);
    chk("term.random_valid", 128'(bus.random_valid), 128'd0);
    chk("term.count64", 128'(sample_count), 128'd64);
    drive(1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b1);
    chk("term.done_once", 128'(done), 128'd0);
    chk("term.late_keep", 128'(bus.coeff_keep), 128'd0);
    chk("term.count_hold", 128'(sample_count), 128'd64);
    drive(1'b1, 8'd7, 1'b0, 64'h0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    chk("restart.sigma", 128'(bus.sigma), 128'd7);
    chk("restart.count", 128'(sample_count), 128'd0);
    drive(1'b0, 8'd0, 1'b1, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("restart.random_valid", 128'(bus.random_valid), 128'd1);
    chk("restart.random_in", bus.random_in, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF);
    drive(1'b1, 8'd9, 1'b0, 64'h0, 1'b1, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("restart.start_ignored_sigma", 128'(bus.sigma), 128'd7);
    chk("restart.refill", 128'(bus.in_ready), 128'd1);

    // Reset in OFFER with 30 samples counted
    drive(1'b0, 8'd0, 1'b1, BA, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, BB, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) drive(1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("mid.count30", 128'(sample_count), 128'd30);
    chk("mid.offer", 128'(bus.random_valid), 128'd1);
    rst_n = 1'b0;
    drive(1'b0, 8'd0, 1'b1, 64'h0, 1'b0, 1'b0);
    chk("mid.in_ready", 128'(bus.in_ready), 128'd0);
    chk("mid.random_valid", 128'(bus.random_valid), 128'd0);
    chk("mid.random_in", bus.random_in, 128'd0);
    chk("mid.sigma", 128'(bus.sigma), 128'd0);
    chk("mid.busy", 128'(busy), 128'd0);
    chk("mid.count", 128'(sample_count), 128'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b0);
      chk($sformatf("mid.no_done%0d", i), 128'(done), 128'd0);
    end

    // Full run against a two-cycle sampler model that rejects words with low nibble F
    drive(1'b1, 8'd4, 1'b0, 64'h0, 1'b0, 1'b0);
    keep_cnt = 0;
    done_cnt = 0;
    post = 0;
    pipe = 2'b00;
    for (int cyc = 0; cyc < 3000 && post < 10; cyc++) begin
      rnd = {$urandom, $urandom};
      drive(1'b0, 8'd0, 1'b1, rnd, 1'b1, pipe[1]);
      keep_cnt += int'(bus.coeff_keep);
      done_cnt += int'(done);
      if (done_cnt > 0) post++;
      pipe = {pipe[0], bus.random_valid && (bus.random_in[3:0] != 4'hF)};
    end
    chk("run.keep_pulses", 128'(keep_cnt), 128'd64);
    chk("run.done_pulses", 128'(done_cnt), 128'd1);
    chk("run.count", 128'(sample_count), 128'd64);
    chk("run.sigma", 128'(bus.sigma), 128'd4);
    drive(1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b1);
    chk("run.late_keep", 128'(bus.coeff_keep), 128'd0);
    chk("run.idle", 128'(busy), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
